// File: rtl/seq_div32.sv
// seq_div32: iterative restoring divider with a start/done handshake.
// Signed operands are reduced to magnitudes at accept time. The core loop
// produces one quotient bit per clock. Signs are applied in a final fix-up
// cycle. Divide-by-zero and signed overflow skip the loop entirely.
module seq_div32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             Si,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             DZ,
    output logic             V
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_SPECIAL,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    // Operation context captured at accept time
    logic [WIDTH-1:0] rem_reg;     // partial remainder
    logic [WIDTH-1:0] dvd_reg;     // dividend magnitude shifting out, quotient shifting in
    logic [WIDTH-1:0] bmag_reg;    // divisor magnitude
    logic [WIDTH-1:0] a_raw_reg;   // raw dividend, returned as remainder on divide-by-zero
    logic             sa_reg;
    logic             sb_reg;
    logic             dz_case_reg; // special path: 1 = divide-by-zero, 0 = signed overflow
    logic [CW-1:0]    cnt_reg;

    // Result registers, held between done pulses
    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] r_reg;
    logic             dz_reg;
    logic             v_reg;

    // Accept-time decode of the incoming operands
    logic             sa_in;
    logic             sb_in;
    logic [WIDTH-1:0] amag_in;
    logic [WIDTH-1:0] bmag_in;
    logic             b_zero;
    logic             ovf_in;

    assign sa_in   = Si & A[WIDTH-1];
    assign sb_in   = Si & B[WIDTH-1];
    assign amag_in = sa_in ? -A : A;
    assign bmag_in = sb_in ? -B : B;
    assign b_zero  = (B == '0);
    assign ovf_in  = Si & (A == MIN_NEG) & (B == ALL_ONES);

    // One restoring step. The shifted remainder is kept at WIDTH+1 bits because
    // an unsigned divisor above 2^(WIDTH-1) lets it exceed WIDTH bits.
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           q_bit;

    assign rem_sh = {rem_reg, dvd_reg[WIDTH-1]};
    assign trial  = rem_sh - {1'b0, bmag_reg};
    assign q_bit  = ~trial[WIDTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic and handshake outputs
    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        case (state_reg)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next = (b_zero | ovf_in) ? S_SPECIAL : S_ITER;
                end
            end
            S_ITER: begin
                if (cnt_reg == CNT_LAST) begin
                    state_next = S_FIX;
                end
            end
            S_FIX:     state_next = S_DONE;
            S_SPECIAL: state_next = S_DONE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default:   state_next = S_IDLE;
        endcase
    end

    // Datapath: capture on accept, iterate, then write the held results
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_reg     <= '0;
            dvd_reg     <= '0;
            bmag_reg    <= '0;
            a_raw_reg   <= '0;
            sa_reg      <= 1'b0;
            sb_reg      <= 1'b0;
            dz_case_reg <= 1'b0;
            cnt_reg     <= '0;
            q_reg       <= '0;
            r_reg       <= '0;
            dz_reg      <= 1'b0;
            v_reg       <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        rem_reg     <= '0;
                        dvd_reg     <= amag_in;
                        bmag_reg    <= bmag_in;
                        a_raw_reg   <= A;
                        sa_reg      <= sa_in;
                        sb_reg      <= sb_in;
                        dz_case_reg <= b_zero;
                        cnt_reg     <= '0;
                    end
                end
                S_ITER: begin
                    rem_reg <= q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
                    dvd_reg <= {dvd_reg[WIDTH-2:0], q_bit};
                    cnt_reg <= cnt_reg + CW'(1);
                end
                S_FIX: begin
                    // Truncating division: remainder follows the dividend's sign.
                    // A zero magnitude negates to zero, so 0/-x stays positive zero.
                    q_reg  <= (sa_reg ^ sb_reg) ? -dvd_reg : dvd_reg;
                    r_reg  <= sa_reg ? -rem_reg : rem_reg;
                    dz_reg <= 1'b0;
                    v_reg  <= 1'b0;
                end
                S_SPECIAL: begin
                    if (dz_case_reg) begin
                        q_reg  <= ALL_ONES;
                        r_reg  <= a_raw_reg;
                        dz_reg <= 1'b1;
                        v_reg  <= 1'b0;
                    end else begin
                        q_reg  <= MIN_NEG;
                        r_reg  <= '0;
                        dz_reg <= 1'b0;
                        v_reg  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign Q  = q_reg;
    assign R  = r_reg;
    assign DZ = dz_reg;
    assign V  = v_reg;

endmodule
